// File: rtl/cr_prefix_fe_seq_pkg.sv
// Shared types and default sizing for the prefix feature-extractor sequence stage.
package cr_prefixPKG;
  localparam int PREFIX_SEQ_NUM_CMP = 4;
  localparam int PREFIX_SEQ_CNT_W   = 8;

  typedef enum logic {IDLE, ACTIVE} prefix_seq_state_e;
endpackage

// File: rtl/cr_prefix_fe_satcnt.sv
// Generic saturating counter with clear. cnt_nxt is the count including this cycle's
// increment (used as the frame result on close); sat flags an increment dropped at all-ones.
module cr_prefix_fe_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_nxt,
  output logic         sat
);
  logic [W-1:0] cnt;

  assign sat     = inc & (&cnt);
  assign cnt_nxt = (inc && !(&cnt)) ? cnt + W'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
endmodule

// File: rtl/cr_prefix_fe_seq.sv
// Ordered multi-character sequence counter; reports a saturating per-frame count at frame end.
// Optional CR_PREFIX_FE_SEQ_SAT_FLAG_EN adds feat_sat (an increment was dropped in the frame).
module cr_prefix_fe_seq
  import cr_prefixPKG::*;
#(
  parameter int NUM_CMP = PREFIX_SEQ_NUM_CMP,
  parameter int CNT_W   = PREFIX_SEQ_CNT_W,
  localparam int LW     = $clog2(NUM_CMP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CMP-1:0] cmp_in,
  input  logic               char_valid_in,
  input  logic               char_last_in,
  input  logic [LW-1:0]      seq_len,
  output logic               feat_valid,
  output logic [CNT_W-1:0]   feat_cnt,
  output logic               feat_hit
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
  ,output logic              feat_sat
`endif
);
  localparam logic [LW-1:0] LEN_MAX = LW'(NUM_CMP - 1);

  prefix_seq_state_e state, state_nxt;
  logic [LW-1:0]     pos, pos_nxt, len_q, len_clamp, eff_len;
  logic              occ, close, cnt_drop;
  logic [CNT_W-1:0]  cnt_nxt;

  generate
    if ((1 << LW) > NUM_CMP) begin : g_clamp
      assign len_clamp = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
    end else begin : g_noclamp
      assign len_clamp = seq_len;
    end
  endgenerate

  assign close = char_valid_in & char_last_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Matching never back-tracks: a miss only re-tests element 0 on the same character.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    occ       = 1'b0;
    eff_len   = (state == IDLE) ? len_clamp : len_q;
    if (char_valid_in) begin
      if (cmp_in[pos]) begin
        if (pos == eff_len) begin
          occ     = 1'b1;
          pos_nxt = '0;
        end else begin
          pos_nxt = pos + LW'(1);
        end
      end else if (cmp_in[0]) begin
        if (eff_len == '0) begin
          occ     = 1'b1;
          pos_nxt = '0;
        end else begin
          pos_nxt = LW'(1);
        end
      end else begin
        pos_nxt = '0;
      end
      if (char_last_in) begin
        state_nxt = IDLE;
        pos_nxt   = '0;
      end else begin
        state_nxt = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      len_q <= '0;
    end else begin
      pos <= pos_nxt;
      if (char_valid_in && state == IDLE) len_q <= len_clamp;
    end
  end

  cr_prefix_fe_satcnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (close),
    .inc     (occ),
    .cnt_nxt (cnt_nxt),
    .sat     (cnt_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_valid <= 1'b0;
      feat_cnt   <= '0;
      feat_hit   <= 1'b0;
    end else begin
      feat_valid <= close;
      if (close) begin
        feat_cnt <= cnt_nxt;
        feat_hit <= |cnt_nxt;
      end
    end
  end

`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q    <= 1'b0;
      feat_sat <= 1'b0;
    end else if (close) begin
      sat_q    <= 1'b0;
      feat_sat <= sat_q | cnt_drop;
    end else if (cnt_drop) begin
      sat_q    <= 1'b1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = cnt_drop;
`endif
endmodule

// File: tb/tb_cr_prefix_fe_seq.sv
// Bench for cr_prefix_fe_seq: directed vector table, hand corner sequences and random
// frames checked against a frame-level reference model. A second instance uses CNT_W=2.
module tb_cr_prefix_fe_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmp_in = '0;
  logic       char_valid_in = 1'b0;
  logic       char_last_in = 1'b0;
  logic [1:0] seq_len = '0;
  logic       feat_valid, feat_hit, feat_valid2, feat_hit2;
  logic [7:0] feat_cnt;
  logic [1:0] feat_cnt2;
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
  logic       feat_sat, feat_sat2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cr_prefix_fe_seq #(.NUM_CMP(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmp_in(cmp_in), .char_valid_in(char_valid_in),
    .char_last_in(char_last_in), .seq_len(seq_len), .feat_valid(feat_valid),
    .feat_cnt(feat_cnt), .feat_hit(feat_hit)
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
    , .feat_sat(feat_sat)
`endif
  );

  cr_prefix_fe_seq #(.NUM_CMP(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmp_in(cmp_in), .char_valid_in(char_valid_in),
    .char_last_in(char_last_in), .seq_len(seq_len), .feat_valid(feat_valid2),
    .feat_cnt(feat_cnt2), .feat_hit(feat_hit2)
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
    , .feat_sat(feat_sat2)
`endif
  );

  // Reference model: store the frame's characters, count occurrences when it closes.
  bit  m_open = 0;
  int  m_lq = 0;
  int  m_q[$];
  int  m_true = 0;
  bit  m_fv = 0;

  function automatic int count_frame(int len);
    int p = 0;
    int n = 0;
    int c;
    foreach (m_q[i]) begin
      c = m_q[i];
      if (c[p]) begin
        if (p == len) begin n++; p = 0; end
        else p++;
      end else if (c[0]) begin
        if (len == 0) begin n++; p = 0; end
        else p = 1;
      end else p = 0;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_open = 0; m_q.delete(); m_true = 0; m_fv = 0;
  endtask

  task automatic model_step(input logic v, input logic l, input logic [3:0] c, input logic [1:0] sl);
    m_fv = 0;
    if (v) begin
      if (!m_open) begin m_open = 1; m_lq = int'(sl); end
      m_q.push_back(int'(c));
      if (l) begin
        m_true = count_frame(m_lq);
        m_fv = 1;
        m_open = 0;
        m_q.delete();
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int e8, e2;
    e8 = (m_true > 255) ? 255 : m_true;
    e2 = (m_true > 3) ? 3 : m_true;
    chk("feat_valid", int'(feat_valid), int'(m_fv));
    chk("feat_cnt", int'(feat_cnt), e8);
    chk("feat_hit", int'(feat_hit), int'(e8 != 0));
    chk("feat_valid_w2", int'(feat_valid2), int'(m_fv));
    chk("feat_cnt_w2", int'(feat_cnt2), e2);
    chk("feat_hit_w2", int'(feat_hit2), int'(e2 != 0));
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
    chk("feat_sat", int'(feat_sat), int'(m_true > 255));
    chk("feat_sat_w2", int'(feat_sat2), int'(m_true > 3));
`endif
  endtask

  task automatic step(input logic v, input logic l, input logic [1:0] sl, input logic [3:0] c);
    char_valid_in = v; char_last_in = l; seq_len = sl; cmp_in = c;
    @(posedge clk);
    #1;
    model_step(v, l, c, sl);
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, int'(feat_valid), 0);
    chk({tag, "_cnt"}, int'(feat_cnt), 0);
    chk({tag, "_hit"}, int'(feat_hit), 0);
    chk({tag, "_cnt_w2"}, int'(feat_cnt2), 0);
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
    chk({tag, "_sat_w2"}, int'(feat_sat2), 0);
`endif
  endtask

  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] sl;
    logic [3:0] c;
    logic       efv;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // v, l, seq_len, cmp, expected feat_valid, expected feat_cnt (after that edge)
    tbl = '{
      // basic count, seq_len=2
      '{1,0,2,4'b0001,0,0}, '{1,0,2,4'b0010,0,0}, '{1,0,2,4'b0100,0,0},
      '{1,0,2,4'b0001,0,0}, '{1,0,2,4'b0010,0,0}, '{1,1,2,4'b0100,1,2},
      // gaps, restart with no back-tracking, unqualified last ignored
      '{1,0,1,4'b0001,0,2}, '{0,0,1,4'b0000,0,2}, '{0,1,1,4'b0000,0,2},
      '{0,0,1,4'b0000,0,2}, '{1,0,1,4'b0001,0,2}, '{1,0,1,4'b0010,0,2},
      '{1,1,1,4'b0000,1,1},
      // single-character frames back to back
      '{1,1,0,4'b0001,1,1}, '{1,1,0,4'b0000,1,0},
      // seq_len latched at frame open
      '{1,0,3,4'b0001,0,0}, '{1,0,0,4'b0010,0,0}, '{1,0,0,4'b0100,0,0},
      '{1,1,0,4'b1000,1,1},
      // length-1 frame of 5 matches, then output hold
      '{1,0,0,4'b0001,0,1}, '{1,0,0,4'b0001,0,1}, '{1,0,0,4'b0001,0,1},
      '{1,0,0,4'b0001,0,1}, '{1,0,0,4'b0001,0,1}, '{1,1,0,4'b0000,1,5},
      '{0,0,0,4'b0000,0,5}, '{0,0,0,4'b0001,0,5}
    };

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].l, tbl[i].sl, tbl[i].c);
      chk($sformatf("vec%0d_valid", i), int'(feat_valid), int'(tbl[i].efv));
      chk($sformatf("vec%0d_cnt", i), int'(feat_cnt), tbl[i].ecnt);
      chk($sformatf("vec%0d_hit", i), int'(feat_hit), int'(tbl[i].ecnt != 0));
    end

    // 5-match frame on the 2-bit counter saturates at 3
    chk("sat_cnt_w2", int'(feat_cnt2), 3);
`ifdef CR_PREFIX_FE_SEQ_SAT_FLAG_EN
    chk("sat_flag_w2", int'(feat_sat2), 1);
    chk("sat_flag_w8", int'(feat_sat), 0);
`endif

    // reset mid-frame discards the partial frame
    step(1, 0, 0, 4'b0001);
    step(1, 0, 0, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_no_valid", int'(feat_valid), 0);
    rst_n = 1'b1;
    step(1, 0, 0, 4'b0001);
    chk("postrst_valid", int'(feat_valid), 0);
    step(1, 1, 0, 4'b0000);
    chk("postrst_valid2", int'(feat_valid), 1);
    chk("postrst_cnt", int'(feat_cnt), 1);

    // random frames against the model
    for (int n = 0; n < 1500; n++) begin
      logic v, l;
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 5) == 0);
      step(v, l, 2'($urandom_range(0, 3)), 4'($urandom));
    end
    step(1, 1, 0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
